// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multicycle RV32 core's memory stage.
//   access_kind_e   : which kind of bus access is in flight
//   mau_state_e     : mem_access_unit state encoding
//   WORD_ALIGN_MASK : clears the byte-offset bits of an address (truncate to ADDR_W)
package riscv_mc_pkg;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } access_kind_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mau_state_e;

    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-wait timeout counter for mem_access_unit.
//   clk, resetn : clock, synchronous active-low reset
//   clr         : restart the count at zero (wins over en)
//   en          : count one wait cycle
//   expire_c    : high in the wait cycle that brings the count to LIMIT
module mem_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Wait-cycle counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    // This cycle's increment would make the count equal LIMIT
    assign expire_c = en && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage of the multicycle RV32 core: turns the control FSM's fetch/load/store
// strobes into a single valid/ready bus transaction and captures read data into
// instr_q (IR) or rdata_q (MDR).
// Optional feature macro: MEM_TIMEOUT_EN -- adds a bus_ready timeout (TIMEOUT_CYCLES)
// with a sticky err and a frozen ERR state; without it err is tied 0.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   fetch_req, mem_read, mem_write  request strobes (store > load > fetch)
//   addr, wdata                  byte address and store data
//   busy                         combinational stall to the control FSM
//   done                         one-cycle completion pulse
//   instr_q, rdata_q             instruction register, memory data register
//   bus_valid, bus_we, bus_addr, bus_wdata, bus_ready, bus_rdata   memory bus
//   err                          sticky timeout error
module mem_access_unit
    import riscv_mc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fetch_req,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] instr_q,
    output logic [DATA_W-1:0] rdata_q,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              err
);

    mau_state_e   state_q;
    mau_state_e   state_d;
    access_kind_e kind_q;
    access_kind_e kind_sel;
    logic         any_req;

    assign any_req = fetch_req | mem_read | mem_write;

    // Request arbitration: store > load > fetch
    always_comb begin
        kind_sel = KIND_FETCH;
        if (mem_write) begin
            kind_sel = KIND_STORE;
        end else if (mem_read) begin
            kind_sel = KIND_LOAD;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic ctr_clr;
    logic ctr_en;
    logic ctr_expire;

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (ctr_clr),
        .en       (ctr_en),
        .expire_c (ctr_expire)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational stall/done; busy rises in the request cycle itself
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    busy    = 1'b1;
                    state_d = BUSY;
`ifdef MEM_TIMEOUT_EN
                    ctr_clr = 1'b1;
`endif
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (bus_ready) begin
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    ctr_en = 1'b1;
                    if (ctr_expire) begin
                        state_d = ERR;
                    end
                end
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                busy = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, bus drive and read-data capture
    always_ff @(posedge clk) begin
        if (!resetn) begin
            kind_q    <= KIND_FETCH;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            instr_q   <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        kind_q    <= kind_sel;
                        bus_valid <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= addr & ADDR_W'(WORD_ALIGN_MASK);
                        bus_wdata <= wdata;
                    end
                end
                BUSY: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (kind_q == KIND_FETCH) begin
                            instr_q <= bus_rdata;
                        end else if (kind_q == KIND_LOAD) begin
                            rdata_q <= bus_rdata;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (ctr_expire) begin
                        bus_valid <= 1'b0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Sticky timeout flag; only reset clears it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (state_q == BUSY && !bus_ready && ctr_expire) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
